// File: rtl/cred_pkg.sv
// Shared credits-layer types and colours, used by the scroll controller and the draw stage.
// 12-bit colours are 4:4:4 RGB.
package cred_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        HOLD   = 2'd2,
        DONE   = 2'd3
    } cred_state_t;

    localparam logic [11:0] BG_COLOR    = 12'h000;
    localparam logic [11:0] TEXT_COLOR  = 12'hFFF;
    localparam logic [11:0] BLINK_COLOR = 12'hF80;

    // Alternate the glyph colour between the normal and the blink value.
    function automatic logic [11:0] blink_swap(input logic [11:0] c);
        return (c == BLINK_COLOR) ? TEXT_COLOR : BLINK_COLOR;
    endfunction

endpackage

// File: rtl/frame_tick.sv
// Frame tick generator: one-cycle pulse on the rising edge of vertical blank.
// Combinational from vblnk_in against its registered copy; no backpressure.
module frame_tick (
    input  logic pclk,
    input  logic rst,
    input  logic vblnk_in,
    output logic tick
);

    logic vblnk_d;

    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_d <= 1'b0;
        end else begin
            vblnk_d <= vblnk_in;
        end
    end

    assign tick = vblnk_in & ~vblnk_d;

endmodule

// File: rtl/cred_scroll_ctrl.sv
// Credits animation: scroll the text box up to its rest row, blink the glyphs, then report done.
// Frame-tick driven updates land one cycle after the tick, i.e. inside vertical blank.
module cred_scroll_ctrl
    import cred_pkg::*;
#(
    parameter int XPOS         = 448,
    parameter int START_Y      = 768,
    parameter int STOP_Y       = 336,
    parameter int STEP         = 2,
    parameter int HOLD_FRAMES  = 180,
    parameter int BLINK_FRAMES = 15
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        start,
    input  logic        skip,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [11:0] color1,
    output logic [11:0] color2,
    output logic        active,
    output logic        done
);

    localparam int HW = (HOLD_FRAMES  > 1) ? $clog2(HOLD_FRAMES)  : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [11:0]   START_YPOS = 12'(START_Y);
    localparam logic [11:0]   STOP_YPOS  = 12'(STOP_Y);
    localparam logic [11:0]   STEP_Y     = 12'(STEP);
    // One bit wider than ypos so the threshold cannot wrap.
    localparam logic [12:0]   SCROLL_MIN = 13'(STOP_Y + STEP);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    cred_state_t   state, state_nxt;
    logic [11:0]   ypos_nxt, color2_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [BW-1:0] blink_cnt, blink_nxt;
    logic          tick;

    frame_tick u_frame_tick (
        .pclk     (pclk),
        .rst      (rst),
        .vblnk_in (vblnk_in),
        .tick     (tick)
    );

    assign xpos   = 12'(XPOS);
    assign color1 = BG_COLOR;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= IDLE;
            ypos      <= START_YPOS;
            color2    <= TEXT_COLOR;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            active    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ypos      <= ypos_nxt;
            color2    <= color2_nxt;
            hold_cnt  <= hold_nxt;
            blink_cnt <= blink_nxt;
            active    <= (state_nxt == SCROLL) || (state_nxt == HOLD);
            done      <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt  = state;
        ypos_nxt   = ypos;
        color2_nxt = color2;
        hold_nxt   = hold_cnt;
        blink_nxt  = blink_cnt;

        unique case (state)
            IDLE: begin
                ypos_nxt   = START_YPOS;
                color2_nxt = TEXT_COLOR;
                if (start) begin
                    state_nxt = SCROLL;
                end
            end

            SCROLL: begin
                color2_nxt = TEXT_COLOR;
                // skip outranks a coincident tick: land at rest with fresh counters.
                if (skip) begin
                    state_nxt = HOLD;
                    ypos_nxt  = STOP_YPOS;
                    hold_nxt  = '0;
                    blink_nxt = '0;
                end else if (tick) begin
                    if ({1'b0, ypos} >= SCROLL_MIN) begin
                        ypos_nxt = ypos - STEP_Y;
                    end else begin
                        state_nxt = HOLD;
                        ypos_nxt  = STOP_YPOS;
                        hold_nxt  = '0;
                        blink_nxt = '0;
                    end
                end
            end

            HOLD: begin
                if (skip || (tick && (hold_cnt == HOLD_LAST))) begin
                    state_nxt  = DONE;
                    ypos_nxt   = START_YPOS;
                    color2_nxt = TEXT_COLOR;
                end else if (tick) begin
                    hold_nxt = hold_cnt + 1'b1;
                    if (blink_cnt == BLINK_LAST) begin
                        blink_nxt  = '0;
                        color2_nxt = blink_swap(color2);
                    end else begin
                        blink_nxt = blink_cnt + 1'b1;
                    end
                end
            end

            DONE: begin
                ypos_nxt   = START_YPOS;
                color2_nxt = TEXT_COLOR;
                if (start) begin
                    state_nxt = SCROLL;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
